instr_fetch_unit: RTL and testbench

- Upstream neighbour of the instruction memory: owns the program counter and issues read requests.
- Captures each returned word and presents an {instr, pc} pair to decode over a valid/ready handshake.
- Handles back-pressure from decode, redirects from execute (branch/jump), and a halt request.
- Never writes instruction memory.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_skid_buf.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit:
//   NOP_INSTR     - word presented on instr_o while nothing is valid
//   SKID_DEPTH    - number of entries in the fetch output buffer
//   fetch_state_e - fetch sequencer states (BOOT, RUN, HALTED)
//   fetch_entry_t - one buffered {pc, instr} pair
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
// Small FIFO of fetch_entry_t sitting between instruction memory and decode.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   push_i/push_data_i - write one entry at the tail
//   pop_i          - drop the head entry (caller only pops when non-empty)
//   flush_i        - empty the buffer; wins over push and pop
//   count_o        - current occupancy
//   head_o         - oldest entry (undefined content when count_o == 0)
// ---------------------------------------------------------------------------
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            push_i,
  input  fetch_entry_t                    push_data_i,
  input  logic                            pop_i,
  input  logic                            flush_i,
  output logic [$clog2(SKID_DEPTH):0]     count_o,
  output fetch_entry_t                    head_o
);

  localparam int PTR_W = $clog2(SKID_DEPTH);

  fetch_entry_t           mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W:0]         count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      // Push and pop together (even when full) leave occupancy unchanged:
      // the write lands in the slot the head is vacating.
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy alone qualifies it.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Owns the program counter, issues reads to instruction memory (1-cycle read
// latency) and hands {instr, pc} pairs to decode over valid/ready.
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   imem_addr_o/imem_rd_en_o - read request (address is 0 when idle)
//   imem_wr_en_o/imem_wdata_o- tied to 0, memory is never written
//   imem_rdata_i             - read data, valid the cycle after the request
//   redirect_i/redirect_pc_i - flush and restart fetch at a word-aligned target
//   halt_i                   - stop issuing new requests while high
//   instr_o/pc_o/valid_o     - head of the output buffer towards decode
//   ready_i                  - decode accepts when valid_o && ready_i
//   halted_o                 - high in HALTED state
// Optional build macro FETCH_PERF_CNT_EN adds fetch_cnt_o (accepted
// handshakes) and flush_cnt_o (redirects), both 32-bit wrapping counters.
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              imem_rd_en_o,
  output logic              imem_wr_en_o,
  output logic [DATA_W-1:0] imem_wdata_o,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              halt_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o,
  input  logic              ready_i,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       flush_cnt_o,
`endif
  output logic              halted_o
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;

  logic              redirect;
  logic              issue;
  logic              push;
  logic              pop;
  logic [1:0]        buf_count;
  logic [2:0]        occ_sum;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  // Redirects are ignored while booting; otherwise they override everything.
  assign redirect = redirect_i && (state_q != BOOT);
  assign pop      = valid_o && ready_i;

  // Slots already claimed: buffered entries plus the outstanding read, less
  // the entry decode is taking this cycle. Counting the pop is what keeps
  // one instruction per cycle flowing when ready_i stays high.
  assign occ_sum = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = (state_q == RUN) && !halt_i && !redirect && (occ_sum < 3'd2);

  // The read issued last cycle returns now. A redirect in this same cycle
  // discards it; since reads never issue during a redirect, no response can
  // arrive later than the redirect cycle, so no separate kill state is kept.
  assign push = inflight_q && !redirect;

  assign push_entry.pc    = 32'(inflight_pc_q);
  assign push_entry.instr = 32'(imem_rdata_i);

  fetch_skid_buf u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect),
    .count_o     (buf_count),
    .head_o      (head)
  );

  always_comb begin
    pc_d = pc_q;
    if (redirect)   pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    else if (issue) pc_d = pc_q + ADDR_W'(4);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
      if (!redirect) begin
        case (state_q)
          BOOT:    state_q <= RUN;
          RUN:     if (halt_i && !inflight_q) state_q <= HALTED;
          HALTED:  if (!halt_i) state_q <= RUN;
          default: state_q <= BOOT;
        endcase
      end
    end
  end

  assign imem_rd_en_o = issue;
  assign imem_addr_o  = issue ? pc_q : '0;
  assign imem_wr_en_o = 1'b0;
  assign imem_wdata_o = '0;

  assign valid_o  = (buf_count != 2'd0);
  assign instr_o  = valid_o ? head.instr[DATA_W-1:0] : NOP_INSTR[DATA_W-1:0];
  assign pc_o     = valid_o ? head.pc[ADDR_W-1:0] : '0;
  assign halted_o = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pop)      fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. Instruction memory returns word == address.
// The scoreboard tracks the PC stream decode should see: sequential words,
// restarted at the aligned target on every redirect.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] imem_addr_o;
  logic        imem_rd_en_o;
  logic        imem_wr_en_o;
  logic [31:0] imem_wdata_o;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;
  logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .imem_addr_o   (imem_addr_o),
    .imem_rd_en_o  (imem_rd_en_o),
    .imem_wr_en_o  (imem_wr_en_o),
    .imem_wdata_o  (imem_wdata_o),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt_o   (fetch_cnt_o),
    .flush_cnt_o   (flush_cnt_o),
`endif
    .halted_o      (halted_o)
  );

  // Memory with one-cycle read latency; each word equals its address.
  always @(posedge clk) begin
    if (imem_rd_en_o) imem_rdata_i <= imem_addr_o;
  end

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          nxfer = 0;
  logic [31:0] exp_pc = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic score();
    if (valid_o && ready_i) begin
      chk("xfer_pc", pc_o, exp_pc);
      chk("xfer_instr", instr_o, exp_pc);
      $display("xfer cycle=%0d pc=%h instr=%h", cyc, pc_o, instr_o);
      exp_pc = exp_pc + 32'd4;
      nxfer++;
    end
    if (redirect_i) exp_pc = {redirect_pc_i[31:2], 2'b00};
    if (halted_o) chk("halted_no_issue", 32'(imem_rd_en_o), 32'd0);
  endtask

  // One clock cycle: drive this cycle's inputs after the edge, let them
  // settle, then score the handshake seen during the cycle.
  task automatic step(input logic rdy, input logic hlt, input logic rdr, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    cyc++;
    ready_i       = rdy;
    halt_i        = hlt;
    redirect_i    = rdr;
    redirect_pc_i = tgt;
    #1;
    if (rst_ni) score();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"},  32'(imem_rd_en_o), 32'd0);
    chk({tag, "_addr"},   imem_addr_o, 32'd0);
    chk({tag, "_valid"},  32'(valid_o), 32'd0);
    chk({tag, "_instr"},  instr_o, 32'h0000_0013);
    chk({tag, "_pc"},     pc_o, 32'd0);
    chk({tag, "_halted"}, 32'(halted_o), 32'd0);
  endtask

  initial begin
    int nx0;
    int halt_left;
    int w;
    logic rdy, hlt, rdr;

    rst_ni        = 1'b0;
    ready_i       = 1'b1;
    halt_i        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;

    // ---- reset state ----
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk_reset_outputs("reset");
    chk("reset_wr_en", 32'(imem_wr_en_o), 32'd0);
    chk("reset_wdata", imem_wdata_o, 32'd0);
    rst_ni = 1'b1;
    cyc    = 0;
    exp_pc = 32'h0;
    chk("cycle0_valid", 32'(valid_o), 32'd0);

    // ---- start-up latency and back-pressure (ready low on cycles 5..10) ----
    for (int c = 1; c <= 13; c++) begin
      step((c < 5) || (c > 10), 1'b0, 1'b0, 32'h0);
      if (c < 3) chk("boot_valid_low", 32'(valid_o), 32'd0);
      if (c == 1) begin
        chk("first_rd_en", 32'(imem_rd_en_o), 32'd1);
        chk("first_addr", imem_addr_o, 32'h0);
      end
      if (c == 3) begin
        chk("first_valid", 32'(valid_o), 32'd1);
        chk("first_pc", pc_o, 32'h0);
        chk("first_instr", instr_o, 32'h0);
      end
      if (c == 4) chk("second_pc", pc_o, 32'h4);
      if (c >= 5 && c <= 10) begin
        chk("bp_rd_en_low", 32'(imem_rd_en_o), 32'd0);
        chk("bp_valid_hold", 32'(valid_o), 32'd1);
        chk("bp_pc_hold", pc_o, 32'h8);
      end
      if (c == 11) begin
        chk("bp_resume_rd_en", 32'(imem_rd_en_o), 32'd1);
        chk("bp_resume_addr", imem_addr_o, 32'h10);
      end
    end

    // ---- redirect to 0x102 with a read in flight (cycle 14) ----
    step(1'b1, 1'b0, 1'b1, 32'h0000_0102);
    chk("redir_no_issue", 32'(imem_rd_en_o), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_flushed", 32'(valid_o), 32'd0);
    chk("redir_rd_en", 32'(imem_rd_en_o), 32'd1);
    chk("redir_addr", imem_addr_o, 32'h100);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_valid", 32'(valid_o), 32'd1);
    chk("redir_pc", pc_o, 32'h100);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0, 32'h0);

    // ---- halt for 6 cycles with ready high ----
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("halt_no_issue", 32'(imem_rd_en_o), 32'd0);
      if (k >= 2) chk("halted_high", 32'(halted_o), 32'd1);
    end
    chk("halt_drained", 32'(valid_o), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("resume_halted_low", 32'(halted_o), 32'd0);
    chk("resume_rd_en", 32'(imem_rd_en_o), 32'd1);
    chk("resume_addr", imem_addr_o, exp_pc);
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 1'b0, 32'h0);

    // ---- asynchronous reset mid-stream ----
    chk("pre_reset_valid", 32'(valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    rst_ni = 1'b1;
    cyc    = 0;
    exp_pc = 32'h0;

    // ---- redirect coinciding with the handshake at pc 8 ----
    for (int c = 1; c <= 5; c++) begin
      step(1'b1, 1'b0, (c == 5), 32'h0000_0200);
      if (c == 3) chk("restart_pc", pc_o, 32'h0);
      if (c == 5) begin
        chk("hs_redir_valid", 32'(valid_o), 32'd1);
        chk("hs_redir_pc", pc_o, 32'h8);
      end
    end
    w = 0;
    do begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      w++;
    end while (!valid_o && w < 8);
    chk("hs_redir_wait", 32'(valid_o), 32'd1);
    chk("hs_redir_target", pc_o, 32'h200);

    // ---- randomized traffic, starting with a redirect near the top of memory ----
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFA);
    nx0       = nxfer;
    halt_left = 0;
    for (int i = 0; i < 1500; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      if (halt_left > 0) halt_left--;
      else if ($urandom_range(0, 59) == 0) halt_left = $urandom_range(1, 8);
      hlt = (halt_left > 0);
      rdr = ($urandom_range(0, 39) == 0);
      step(rdy, hlt, rdr, $urandom());
    end
    chk("random_progress", 32'(nxfer - nx0 > 300), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
